dct_arbiter: RTL and testbench

DCT_ARBITER -- requirements
Module: dct_arbiter

---
 rtl/dct_pkg.sv | 14 +
 rtl/dct_arbiter_if.sv | 41 ++++
 rtl/dct_owner_fifo.sv | 66 ++++++
 rtl/dct_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_dct_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared widths, beat count and FSM encoding for the DCT arbiter
package dct_pkg;
    localparam int BEATS    = 8;
    localparam int SAMPLE_W = 8;
    localparam int COEF_W   = 18;
    localparam int IDX_W    = 4;
    localparam int BEAT_W   = $clog2(BEATS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_STREAM = 2'd2
    } state_t;
endpackage

// File: rtl/dct_arbiter_if.sv
// rtl/dct_arbiter_if.sv - requester/core signal bundle for the DCT arbiter
interface dct_arbiter_if
    import dct_pkg::*;
#(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]          req;
    logic [N_REQ-1:0]          gnt;
    logic [N_REQ-1:0]          s_valid;
    logic [SAMPLE_W*N_REQ-1:0] s_a_flat;
    logic [SAMPLE_W*N_REQ-1:0] s_b_flat;
    logic                      dct_start;
    logic [SAMPLE_W-1:0]       dct_a;
    logic [SAMPLE_W-1:0]       dct_b;
    logic signed [COEF_W-1:0]  dct_out_a;
    logic signed [COEF_W-1:0]  dct_out_b;
    logic [IDX_W-1:0]          dct_idx_a;
    logic [IDX_W-1:0]          dct_idx_b;
    logic                      dct_out_en;
    logic signed [COEF_W-1:0]  r_a;
    logic signed [COEF_W-1:0]  r_b;
    logic [IDX_W-1:0]          r_idx_a;
    logic [IDX_W-1:0]          r_idx_b;
    logic [N_REQ-1:0]          r_valid;
    logic                      busy;
    logic                      proto_err;

    modport master (
        output req, s_valid, s_a_flat, s_b_flat,
        output dct_out_a, dct_out_b, dct_idx_a, dct_idx_b, dct_out_en,
        input  gnt, dct_start, dct_a, dct_b,
        input  r_a, r_b, r_idx_a, r_idx_b, r_valid, busy, proto_err
    );

    modport slave (
        input  req, s_valid, s_a_flat, s_b_flat,
        input  dct_out_a, dct_out_b, dct_idx_a, dct_idx_b, dct_out_en,
        output gnt, dct_start, dct_a, dct_b,
        output r_a, r_b, r_idx_a, r_idx_b, r_valid, busy, proto_err
    );
endinterface

// File: rtl/dct_owner_fifo.sv
// rtl/dct_owner_fifo.sv - small FIFO of requester IDs awaiting their result block
module dct_owner_fifo #(
    parameter int DEPTH = 2,
    parameter int ID_W  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output logic [ID_W-1:0] head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ID_W-1:0]  mem_q [DEPTH];
    logic [ID_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign head  = mem_q[rd_q];

    // A pop frees the slot in the same cycle, so push-while-full is legal alongside it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = push_id;
            wr_d = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_d = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/dct_arbiter.sv
// rtl/dct_arbiter.sv - round-robin arbiter sharing one DCT core between requesters
// Optional per-requester result-block counters: define DCT_ARB_STATS_EN.
module dct_arbiter
    import dct_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int OWN_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    output logic [N_REQ-1:0]          gnt,
    input  logic [N_REQ-1:0]          s_valid,
    input  logic [SAMPLE_W*N_REQ-1:0] s_a_flat,
    input  logic [SAMPLE_W*N_REQ-1:0] s_b_flat,
    output logic                      dct_start,
    output logic [SAMPLE_W-1:0]       dct_a,
    output logic [SAMPLE_W-1:0]       dct_b,
    input  logic signed [COEF_W-1:0]  dct_out_a,
    input  logic signed [COEF_W-1:0]  dct_out_b,
    input  logic [IDX_W-1:0]          dct_idx_a,
    input  logic [IDX_W-1:0]          dct_idx_b,
    input  logic                      dct_out_en,
    output logic signed [COEF_W-1:0]  r_a,
    output logic signed [COEF_W-1:0]  r_b,
    output logic [IDX_W-1:0]          r_idx_a,
    output logic [IDX_W-1:0]          r_idx_b,
    output logic [N_REQ-1:0]          r_valid,
    output logic                      busy,
    output logic                      proto_err
`ifdef DCT_ARB_STATS_EN
    ,
    output logic [16*N_REQ-1:0]       blk_cnt_flat
`endif
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t                   state_q, state_d;
    logic [ID_W-1:0]          winner_q, winner_d, last_q, last_d, pick, head;
    logic [BEAT_W-1:0]        beat_q, beat_d, res_cnt_q, res_cnt_d;
    logic                     dct_start_q, dct_start_d;
    logic [SAMPLE_W-1:0]      dct_a_q, dct_a_d, dct_b_q, dct_b_d;
    logic signed [COEF_W-1:0] r_a_q, r_a_d, r_b_q, r_b_d;
    logic [IDX_W-1:0]         r_idx_a_q, r_idx_a_d, r_idx_b_q, r_idx_b_d;
    logic [N_REQ-1:0]         r_valid_q, r_valid_d;
    logic                     err_q, err_d;
    logic                     push, pop, full, empty;
    int                       idx;

    // Scan downward so the requester closest after last_q is the final assignment.
    always_comb begin
        pick = last_q;
        idx  = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last_q) + k) % N_REQ;
            if (req[idx]) begin
                pick = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        last_d      = last_q;
        beat_d      = beat_q;
        res_cnt_d   = res_cnt_q;
        dct_start_d = 1'b0;
        dct_a_d     = '0;
        dct_b_d     = '0;
        r_a_d       = r_a_q;
        r_b_d       = r_b_q;
        r_idx_a_d   = r_idx_a_q;
        r_idx_b_d   = r_idx_b_q;
        r_valid_d   = '0;
        err_d       = err_q;
        push        = 1'b0;
        pop         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req && !full) begin
                    winner_d = pick;
                    last_d   = pick;
                    state_d  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                push    = 1'b1;
                beat_d  = '0;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (s_valid[winner_q]) begin
                    dct_a_d     = s_a_flat[int'(winner_q)*SAMPLE_W +: SAMPLE_W];
                    dct_b_d     = s_b_flat[int'(winner_q)*SAMPLE_W +: SAMPLE_W];
                    dct_start_d = (beat_q == '0);
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        beat_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (dct_out_en) begin
            r_a_d     = dct_out_a;
            r_b_d     = dct_out_b;
            r_idx_a_d = dct_idx_a;
            r_idx_b_d = dct_idx_b;
            if (empty) begin
                err_d = 1'b1;
            end else begin
                r_valid_d = N_REQ'(1) << head;
                pop       = (res_cnt_q == BEAT_W'(BEATS - 1));
                res_cnt_d = res_cnt_q + BEAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            winner_q    <= '0;
            last_q      <= ID_W'(N_REQ - 1);
            beat_q      <= '0;
            res_cnt_q   <= '0;
            dct_start_q <= 1'b0;
            dct_a_q     <= '0;
            dct_b_q     <= '0;
            r_a_q       <= '0;
            r_b_q       <= '0;
            r_idx_a_q   <= '0;
            r_idx_b_q   <= '0;
            r_valid_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            last_q      <= last_d;
            beat_q      <= beat_d;
            res_cnt_q   <= res_cnt_d;
            dct_start_q <= dct_start_d;
            dct_a_q     <= dct_a_d;
            dct_b_q     <= dct_b_d;
            r_a_q       <= r_a_d;
            r_b_q       <= r_b_d;
            r_idx_a_q   <= r_idx_a_d;
            r_idx_b_q   <= r_idx_b_d;
            r_valid_q   <= r_valid_d;
            err_q       <= err_d;
        end
    end

    dct_owner_fifo #(
        .DEPTH (OWN_DEPTH),
        .ID_W  (ID_W)
    ) u_owner_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push    (push),
        .push_id (winner_q),
        .pop     (pop),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

    assign gnt       = (state_q == ST_GRANT) ? (N_REQ'(1) << winner_q) : '0;
    assign busy      = (state_q != ST_IDLE) || !empty;
    assign dct_start = dct_start_q;
    assign dct_a     = dct_a_q;
    assign dct_b     = dct_b_q;
    assign r_a       = r_a_q;
    assign r_b       = r_b_q;
    assign r_idx_a   = r_idx_a_q;
    assign r_idx_b   = r_idx_b_q;
    assign r_valid   = r_valid_q;
    assign proto_err = err_q;

`ifdef DCT_ARB_STATS_EN
    logic [N_REQ-1:0][15:0] blk_cnt_q, blk_cnt_d;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (pop && blk_cnt_q[head] != 16'hFFFF) begin
            blk_cnt_d[head] = blk_cnt_q[head] + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blk_cnt_q <= '0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign blk_cnt_flat = blk_cnt_q;
`endif
endmodule

// File: tb/tb_dct_arbiter.sv
// tb/tb_dct_arbiter.sv - scoreboard bench for dct_arbiter
module tb_dct_arbiter;
    import dct_pkg::*;

    localparam int N = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dct_arbiter_if #(.N_REQ(N)) bus();
`ifdef DCT_ARB_STATS_EN
    logic [16*N-1:0] blk_cnt_flat;
`endif

    dct_arbiter #(.N_REQ(N), .OWN_DEPTH(2)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .req        (bus.req),
        .gnt        (bus.gnt),
        .s_valid    (bus.s_valid),
        .s_a_flat   (bus.s_a_flat),
        .s_b_flat   (bus.s_b_flat),
        .dct_start  (bus.dct_start),
        .dct_a      (bus.dct_a),
        .dct_b      (bus.dct_b),
        .dct_out_a  (bus.dct_out_a),
        .dct_out_b  (bus.dct_out_b),
        .dct_idx_a  (bus.dct_idx_a),
        .dct_idx_b  (bus.dct_idx_b),
        .dct_out_en (bus.dct_out_en),
        .r_a        (bus.r_a),
        .r_b        (bus.r_b),
        .r_idx_a    (bus.r_idx_a),
        .r_idx_b    (bus.r_idx_b),
        .r_valid    (bus.r_valid),
        .busy       (bus.busy),
        .proto_err  (bus.proto_err)
`ifdef DCT_ARB_STATS_EN
        ,
        .blk_cnt_flat (blk_cnt_flat)
`endif
    );

    typedef struct {
        int         due;
        logic       start;
        logic [7:0] a;
        logic [7:0] b;
    } dct_exp_t;

    typedef struct {
        int          due;
        logic [17:0] a;
        logic [17:0] b;
        logic [3:0]  ia;
        logic [3:0]  ib;
        logic [N-1:0] rv;
    } r_exp_t;

    int       checks = 0;
    int       failures = 0;
    int       cyc = 0;
    dct_exp_t exp_dct[$];
    r_exp_t   exp_r[$];
    int       exp_gnt[$];
    int       own_model[$];
    int       res_k = 0;
    int       gnt_count = 0;
    int       gnt_cyc = 0;
    int       stall_beat = -1;
    int       drv_beat = -1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    task automatic flush();
        exp_dct.delete();
        exp_r.delete();
        exp_gnt.delete();
        own_model.delete();
        res_k = 0;
        stall_beat = -1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush();
        bus.req = '0;
        bus.dct_out_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"}, bus.gnt, 0);
        check({tag, "_start"}, bus.dct_start, 0);
        check({tag, "_dct_a"}, bus.dct_a, 0);
        check({tag, "_dct_b"}, bus.dct_b, 0);
        check({tag, "_r_valid"}, bus.r_valid, 0);
        check({tag, "_r_a"}, $unsigned(bus.r_a), 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_err"}, bus.proto_err, 0);
    endtask

    // Monitor: grants, sample beats and result beats against the scoreboard queues.
    initial begin
        int       id;
        dct_exp_t de;
        r_exp_t   re;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.gnt != '0) begin
                    gnt_count++;
                    gnt_cyc = cyc;
                    if (exp_gnt.size() == 0) begin
                        check("gnt_unexpected", bus.gnt, 0);
                    end else begin
                        id = exp_gnt.pop_front();
                        check("gnt", bus.gnt, N'(1) << id);
                        own_model.push_back(id);
                    end
                end
                if (exp_dct.size() > 0 && exp_dct[0].due == cyc) begin
                    de = exp_dct.pop_front();
                    check("dct_start", bus.dct_start, de.start);
                    check("dct_a", bus.dct_a, de.a);
                    check("dct_b", bus.dct_b, de.b);
                end else begin
                    check("dct_start_idle", bus.dct_start, 0);
                end
                if (exp_r.size() > 0 && exp_r[0].due == cyc) begin
                    re = exp_r.pop_front();
                    check("r_valid", bus.r_valid, re.rv);
                    check("r_a", $unsigned(bus.r_a), re.a);
                    check("r_b", $unsigned(bus.r_b), re.b);
                    check("r_idx_a", bus.r_idx_a, re.ia);
                    check("r_idx_b", bus.r_idx_b, re.ib);
                end else begin
                    check("r_valid_idle", bus.r_valid, 0);
                end
            end
        end
    end

    // Requester model: after a grant, present eight beats of the winner's block.
    initial begin
        int         id;
        int         beat;
        bit         stalled;
        logic [7:0] va, vb;
        forever begin
            @(negedge clk);
            if (rst_n && bus.gnt != '0) begin
                id = 0;
                for (int i = 0; i < N; i++) if (bus.gnt[i]) id = i;
                beat = 0;
                stalled = 1'b0;
                while (beat < BEATS) begin
                    @(posedge clk);
                    #1;
                    if (!rst_n) break;
                    if (beat == stall_beat && !stalled) begin
                        stalled = 1'b1;
                        bus.s_valid[id] = 1'b0;
                        bus.s_a_flat[8*id +: 8] = 8'hEE;
                        bus.s_b_flat[8*id +: 8] = 8'hEE;
                        exp_dct.push_back('{cyc + 1, 1'b0, 8'h00, 8'h00});
                    end else begin
                        va = 8'(id * 8'h40 + 2 * beat + 1);
                        vb = 8'(id * 8'h40 + 2 * beat + 2);
                        bus.s_valid[id] = 1'b1;
                        bus.s_a_flat[8*id +: 8] = va;
                        bus.s_b_flat[8*id +: 8] = vb;
                        exp_dct.push_back('{cyc + 1, beat == 0, va, vb});
                        drv_beat = beat;
                        beat++;
                    end
                end
                @(posedge clk);
                #1;
                bus.s_valid = '0;
                drv_beat = -1;
            end
        end
    end

    task automatic wait_grant(input int base, input string tag);
        int n = 0;
        while (gnt_count <= base && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_seen"}, gnt_count > base, 1);
    endtask

    task automatic send_results(input int n, input int base_v, output int last_c);
        logic [17:0]  va, vb;
        logic [N-1:0] rv;
        last_c = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            va = 18'(base_v + k);
            vb = 18'(-(base_v + k));
            bus.dct_out_en = 1'b1;
            bus.dct_out_a = va;
            bus.dct_out_b = vb;
            bus.dct_idx_a = 4'(k);
            bus.dct_idx_b = 4'(7 - k);
            rv = '0;
            if (own_model.size() > 0) begin
                rv = N'(1) << own_model[0];
                res_k++;
                if (res_k == BEATS) begin
                    void'(own_model.pop_front());
                    res_k = 0;
                end
            end
            exp_r.push_back('{cyc + 1, va, vb, 4'(k), 4'(7 - k), rv});
            last_c = cyc;
        end
        @(posedge clk);
        #1 bus.dct_out_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, lc, prev, n;
        bus.req = '0;
        bus.s_valid = '0;
        bus.s_a_flat = '0;
        bus.s_b_flat = '0;
        bus.dct_out_en = 1'b0;
        bus.dct_out_a = '0;
        bus.dct_out_b = '0;
        bus.dct_idx_a = '0;
        bus.dct_idx_b = '0;
        #2 check_zero("rst");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request from requester 0
        base = gnt_count;
        exp_gnt.push_back(0);
        bus.req = 2'b01;
        wait_grant(base, "single");
        bus.req = '0;
        repeat (12) @(posedge clk);
        #1;
        check("single_busy", bus.busy, 1);
        check("single_err", bus.proto_err, 0);
        send_results(8, 100, lc);
        repeat (3) @(posedge clk);
        #1 check("single_done_busy", bus.busy, 0);

        // Contention with both requests held
        do_reset();
        for (int i = 0; i < 4; i++) exp_gnt.push_back(i % 2);
        bus.req = 2'b11;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            base = gnt_count;
            wait_grant(base, "cont");
            if (i > 0) check("cont_spacing", gnt_cyc - prev, 10);
            prev = gnt_cyc;
            if (i == 3) bus.req = '0;
            send_results(8, 200 + 16 * i, lc);
        end
        repeat (4) @(posedge clk);
        #1 check("cont_done_busy", bus.busy, 0);

        // Owner FIFO full: third grant waits for the first result block to finish
        do_reset();
        exp_gnt.push_back(0);
        exp_gnt.push_back(1);
        bus.req = 2'b11;
        base = gnt_count;
        wait_grant(base, "full_g0");
        wait_grant(base + 1, "full_g1");
        repeat (30) @(posedge clk);
        #1;
        check("full_busy", bus.busy, 1);
        check("full_no_third", gnt_count, base + 2);
        exp_gnt.push_back(0);
        base = gnt_count;
        send_results(8, 300, lc);
        wait_grant(base, "full_g2");
        check("full_after_pop", gnt_cyc > lc + 1, 1);
        bus.req = '0;
        send_results(16, 400, lc);
        repeat (4) @(posedge clk);
        #1 check("full_done_busy", bus.busy, 0);

        // Protocol error: s_valid dropped on beat 3
        do_reset();
        stall_beat = 3;
        exp_gnt.push_back(1);
        base = gnt_count;
        bus.req = 2'b10;
        wait_grant(base, "perr");
        bus.req = '0;
        repeat (14) @(posedge clk);
        #1 check("perr_flag", bus.proto_err, 1);
        send_results(8, 500, lc);
        repeat (3) @(posedge clk);
        #1 check("perr_done_busy", bus.busy, 0);

        // Orphan result beat
        do_reset();
        check("orphan_err_before", bus.proto_err, 0);
        send_results(1, 600, lc);
        repeat (2) @(posedge clk);
        #1 check("orphan_err", bus.proto_err, 1);

        // Reset during beat 4 of a stream
        do_reset();
        exp_gnt.push_back(0);
        base = gnt_count;
        bus.req = 2'b01;
        wait_grant(base, "mr");
        bus.req = '0;
        n = 0;
        while (drv_beat != 4 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("mr_beat4", drv_beat, 4);
        rst_n = 1'b0;
        flush();
        #1 check_zero("mr");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_gnt.push_back(1);
        base = gnt_count;
        bus.req = 2'b10;
        wait_grant(base, "mr_g1");
        bus.req = '0;
        repeat (12) @(posedge clk);
        send_results(8, 700, lc);
        repeat (3) @(posedge clk);
        #1;
        check("mr_done_busy", bus.busy, 0);
        check("mr_err", bus.proto_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
